// File: rtl/burst_bus_pkg.sv
// Shared definitions for the serial burst bus: slave FSM states and frame modes.
package burst_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_LEN   = 3'd2,
        ST_WDATA = 3'd3,
        ST_RWAIT = 3'd4,
        ST_RDATA = 3'd5
    } state_t;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

endpackage

// File: rtl/burst_slave_mem.sv
// Single-port word memory with a fixed read latency; out-of-range addresses
// drop writes and read back as zero.
module burst_slave_mem #(
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 8,
    parameter int MEM_SIZE     = 4096,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  wen,
    input  logic                  ren,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

    logic [DATA_WIDTH-1:0] mem  [MEM_SIZE];
    logic [DATA_WIDTH-1:0] pipe [READ_LATENCY];
    logic                  in_range;
    logic [IDX_W-1:0]      idx;

    assign in_range = 32'(addr) < MEM_SIZE;
    assign idx      = addr[IDX_W-1:0];

    // Array access plus the read-latency pipeline; rdata is the last stage.
    // NOTE: the array and the data pipeline carry no reset; contents must survive rst and a
    // reset term would stop the array from mapping onto RAM.
    always_ff @(posedge clk) begin
        if (wen && in_range) begin
            mem[idx] <= wdata;
        end
        if (ren) begin
            pipe[0] <= in_range ? mem[idx] : '0;
        end
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe[i] <= pipe[i-1];
        end
    end

    assign rdata = pipe[READ_LATENCY-1];

endmodule

// File: rtl/burst_slave.sv
// Serial burst slave: decodes address/length/write-data frames bit by bit,
// commits write beats to memory and streams read bursts back without gaps.
import burst_bus_pkg::*;

module burst_slave #(
    parameter int ADDR_WIDTH      = 12,
    parameter int DATA_WIDTH      = 8,
    parameter int MEM_SIZE        = 4096,
    parameter int BURST_LEN_WIDTH = 4,
    parameter int READ_LATENCY    = 2,
    parameter int SPLIT_EN        = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic swdata,
    input  logic smode,
    input  logic mvalid,
    output logic srdata,
    output logic svalid,
    output logic sready,
    output logic ssplit
);

    localparam int AW  = ADDR_WIDTH;
    localparam int DW  = DATA_WIDTH;
    localparam int LW  = BURST_LEN_WIDTH;
    localparam int M1  = (AW > LW) ? AW : LW;
    localparam int M2  = (DW > READ_LATENCY) ? DW : READ_LATENCY;
    localparam int CNT_MAX = (M1 > M2) ? M1 : M2;
    localparam int CW  = $clog2(CNT_MAX + 1);
    localparam int TW  = (DW > 1) ? $clog2(DW) : 1;

    state_t          state;
    logic            mode;
    logic [AW-1:0]   addr_sh;
    logic [LW-1:0]   len_sh;
    logic [DW-1:0]   wsh;
    logic [DW-1:0]   rsh;
    logic [CW-1:0]   cnt;
    logic [LW-1:0]   beat;
    logic [AW-1:0]   baddr;
    logic            wen_q;
    logic [AW-1:0]   wc_addr;
    logic [DW-1:0]   wc_data;
    logic [LW:0]     rd_issued;
    logic [TW-1:0]   rd_tmr;
    logic            ren;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   rdata;

    // Beat addresses wrap from the top of memory back to zero.
    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
        return (32'(a) == MEM_SIZE - 1) ? '0 : a + 1'b1;
    endfunction

    // One read per DW cycles, starting the cycle after the length field, so each
    // beat's data lands exactly when the previous beat finishes shifting out.
    assign ren = ((state == ST_RWAIT) || (state == ST_RDATA)) &&
                 (rd_tmr == '0) && (rd_issued <= {1'b0, len_sh});

    assign mem_addr = wen_q ? wc_addr : baddr;

    burst_slave_mem #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .MEM_SIZE    (MEM_SIZE),
        .READ_LATENCY(READ_LATENCY)
    ) u_mem (
        .clk  (clk),
        .wen  (wen_q),
        .ren  (ren),
        .addr (mem_addr),
        .wdata(wc_data),
        .rdata(rdata)
    );

    // Frame decoder, write-beat commit and read-burst sequencing.
    // NOTE: every register here uses <= so all updates see the pre-edge values,
    // matching the flop behaviour the shift registers depend on.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            mode      <= MODE_READ;
            addr_sh   <= '0;
            len_sh    <= '0;
            wsh       <= '0;
            rsh       <= '0;
            cnt       <= '0;
            beat      <= '0;
            baddr     <= '0;
            wen_q     <= 1'b0;
            wc_addr   <= '0;
            wc_data   <= '0;
            rd_issued <= '0;
            rd_tmr    <= '0;
        end else begin
            wen_q <= 1'b0;
            if (ren) begin
                baddr     <= next_addr(baddr);
                rd_issued <= rd_issued + 1'b1;
            end
            if ((state == ST_RWAIT) || (state == ST_RDATA)) begin
                rd_tmr <= (rd_tmr == TW'(DW - 1)) ? '0 : rd_tmr + 1'b1;
            end
            case (state)
                ST_IDLE: if (mvalid) begin
                    mode    <= smode;
                    addr_sh <= {swdata, addr_sh[AW-1:1]};
                    cnt     <= CW'(1);
                    state   <= ST_ADDR;
                end
                ST_ADDR: if (mvalid) begin
                    addr_sh <= {swdata, addr_sh[AW-1:1]};
                    if (cnt == CW'(AW - 1)) begin
                        baddr <= {swdata, addr_sh[AW-1:1]};
                        cnt   <= '0;
                        state <= ST_LEN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_LEN: if (mvalid) begin
                    len_sh <= {swdata, len_sh[LW-1:1]};
                    if (cnt == CW'(LW - 1)) begin
                        cnt       <= '0;
                        beat      <= '0;
                        rd_issued <= '0;
                        rd_tmr    <= '0;
                        state     <= (mode == MODE_WRITE) ? ST_WDATA : ST_RWAIT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_WDATA: if (mvalid) begin
                    wsh <= {swdata, wsh[DW-1:1]};
                    if (cnt == CW'(DW - 1)) begin
                        cnt     <= '0;
                        wen_q   <= 1'b1;
                        wc_addr <= baddr;
                        wc_data <= {swdata, wsh[DW-1:1]};
                        baddr   <= next_addr(baddr);
                        if (beat == len_sh) begin
                            state <= ST_IDLE;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RWAIT: begin
                    if (cnt == CW'(READ_LATENCY - 1)) begin
                        cnt   <= '0;
                        state <= ST_RDATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RDATA: begin
                    rsh <= (cnt == '0) ? (rdata >> 1) : (rsh >> 1);
                    if (cnt == CW'(DW - 1)) begin
                        cnt <= '0;
                        if (beat == len_sh) begin
                            state <= ST_IDLE;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Status outputs decode straight from the state; bit 0 of a beat comes
    // from the memory output, the rest from the shift register.
    assign sready = (state == ST_IDLE);
    assign svalid = (state == ST_RDATA);
    assign srdata = svalid && ((cnt == '0) ? rdata[0] : rsh[0]);
    assign ssplit = (SPLIT_EN != 0) && (state == ST_RWAIT);

endmodule

// File: tb/tb_burst_slave.sv
// Self-checking bench for burst_slave: two instances (default, and a small
// split-enabled memory with longer latency) checked every cycle against a
// frame-level memory model, plus literal expectations for the directed cases.
module tb_burst_slave;

    localparam int AW  = 12;
    localparam int LW  = 4;
    localparam int DW  = 8;
    localparam int RL0 = 2;
    localparam int RL1 = 4;
    localparam int MS0 = 4096;
    localparam int MS1 = 2048;

    logic clk = 1'b0;
    logic rst    [2];
    logic swdata [2];
    logic smode  [2];
    logic mvalid [2];
    logic srdata [2];
    logic svalid [2];
    logic sready [2];
    logic ssplit [2];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_t   = 0;
    bit chk_en   = 1'b0;

    logic [7:0] wbuf [16];
    byte unsigned mem_m0 [int];
    byte unsigned mem_m1 [int];
    bit exp_b0 [int];
    bit exp_b1 [int];
    bit exp_s1 [int];
    bit cap0 [$];
    bit cap1 [$];
    int vcyc0 [$];
    int vcyc1 [$];
    int split1 [$];

    burst_slave u_dut0 (
        .clk(clk), .rst(rst[0]), .swdata(swdata[0]), .smode(smode[0]), .mvalid(mvalid[0]),
        .srdata(srdata[0]), .svalid(svalid[0]), .sready(sready[0]), .ssplit(ssplit[0])
    );

    burst_slave #(
        .MEM_SIZE(MS1), .READ_LATENCY(RL1), .SPLIT_EN(1)
    ) u_dut1 (
        .clk(clk), .rst(rst[1]), .swdata(swdata[1]), .smode(smode[1]), .mvalid(mvalid[1]),
        .srdata(srdata[1]), .svalid(svalid[1]), .sready(sready[1]), .ssplit(ssplit[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic bit rb();
        return 1'($urandom);
    endfunction

    // Memory model: beat addresses step by one and wrap at the memory top.
    function automatic int nxt(input int d, input int a);
        int ms;
        ms = (d == 1) ? MS1 : MS0;
        return (a == ms - 1) ? 0 : (a + 1) % (1 << AW);
    endfunction

    function automatic int mrd(input int d, input int a);
        if (a >= ((d == 1) ? MS1 : MS0)) return 0;
        return (d == 1) ? int'(mem_m1[a]) : int'(mem_m0[a]);
    endfunction

    function automatic void mwr(input int d, input int a, input int v);
        if (a >= ((d == 1) ? MS1 : MS0)) return;
        if (d == 1) mem_m1[a] = 8'(v);
        else        mem_m0[a] = 8'(v);
    endfunction

    function automatic void set_exp(input int d, input int c, input bit b);
        if (d == 1) exp_b1[c] = b;
        else        exp_b0[c] = b;
    endfunction

    function automatic int cap_byte(input int d, input int k);
        int v;
        v = 0;
        for (int i = 0; i < DW; i++) begin
            if (d == 1) v |= (k * DW + i < cap1.size()) ? (int'(cap1[k*DW+i]) << i) : 0;
            else        v |= (k * DW + i < cap0.size()) ? (int'(cap0[k*DW+i]) << i) : 0;
        end
        return v;
    endfunction

    task automatic clear_cap();
        cap0.delete();
        cap1.delete();
        vcyc0.delete();
        vcyc1.delete();
        split1.delete();
    endtask

    task automatic drive(input int d, input bit v, input bit b, input bit m);
        @(posedge clk);
        #1;
        mvalid[d] = v;
        swdata[d] = b;
        smode[d]  = m;
    endtask

    // gap >= 0: that many idle cycles before every bit; gap < 0: random gaps.
    task automatic send_bits(input int d, input int val, input int n, input int gap, input bit m);
        int g;
        for (int i = 0; i < n; i++) begin
            if (gap >= 0) g = gap;
            else          g = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            repeat (g) drive(d, 1'b0, rb(), rb());
            drive(d, 1'b1, 1'((val >> i) & 1), m);
        end
    endtask

    // One complete frame; reads register their expected stream per cycle and
    // keep garbage on mvalid for the whole read to show it is ignored.
    task automatic frame(input int d, input bit wr, input int a, input int len, input int gap);
        int t, rl, nb, ak, v;
        drive(d, 1'b0, rb(), rb());
        check($sformatf("sready_idle%0d", d), sready[d], 1);
        send_bits(d, a, AW, gap, wr);
        send_bits(d, len, LW, gap, wr);
        if (wr) begin
            for (int k = 0; k <= len; k++) send_bits(d, int'(wbuf[k]), DW, gap, wr);
            ak = a;
            for (int k = 0; k <= len; k++) begin
                mwr(d, ak, int'(wbuf[k]));
                ak = nxt(d, ak);
            end
        end else begin
            t      = cyc;
            last_t = t;
            rl     = (d == 1) ? RL1 : RL0;
            ak     = a;
            for (int k = 0; k <= len; k++) begin
                v = mrd(d, ak);
                for (int i = 0; i < DW; i++) set_exp(d, t + 1 + rl + k * DW + i, 1'((v >> i) & 1));
                ak = nxt(d, ak);
            end
            if (d == 1) for (int j = 1; j <= rl; j++) exp_s1[t + j] = 1'b1;
            nb = rl + (len + 1) * DW;
            for (int j = 0; j < nb; j++) begin
                drive(d, rb(), rb(), rb());
                if (j == nb / 2) check($sformatf("sready_busy%0d", d), sready[d], 0);
            end
            drive(d, 1'b0, rb(), rb());
            check($sformatf("sready_done%0d", d), sready[d], 1);
        end
    endtask

    // Capture of the read streams for the directed literal checks.
    always @(negedge clk) begin
        if (svalid[0] === 1'b1) begin cap0.push_back(srdata[0]); vcyc0.push_back(cyc); end
        if (svalid[1] === 1'b1) begin cap1.push_back(srdata[1]); vcyc1.push_back(cyc); end
        if (ssplit[1] === 1'b1) split1.push_back(cyc);
    end

    // Cycle-by-cycle comparison against the model's expected streams.
    always @(negedge clk) begin
        if (chk_en) begin
            check("svalid0", svalid[0], exp_b0.exists(cyc));
            check("srdata0", srdata[0], exp_b0.exists(cyc) ? exp_b0[cyc] : 1'b0);
            check("svalid1", svalid[1], exp_b1.exists(cyc));
            check("srdata1", srdata[1], exp_b1.exists(cyc) ? exp_b1[cyc] : 1'b0);
            check("ssplit0", ssplit[0], 0);
            check("ssplit1", ssplit[1], exp_s1.exists(cyc));
        end
    end

    initial begin
        int r, len, a;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; mvalid[d] = 1'b0; swdata[d] = 1'b0; smode[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_sready%0d", d), sready[d], 1);
            check($sformatf("rst_svalid%0d", d), svalid[d], 0);
            check($sformatf("rst_srdata%0d", d), srdata[d], 0);
            check($sformatf("rst_ssplit%0d", d), ssplit[d], 0);
            rst[d] = 1'b0;
        end
        chk_en = 1'b1;

        // Single beat write/read-back with exact first-valid timing.
        wbuf[0] = 8'hA5;
        frame(0, 1'b1, 'h010, 0, 0);
        clear_cap();
        frame(0, 1'b0, 'h010, 0, 0);
        check("a5_len", cap0.size(), 8);
        check("a5_start", (vcyc0.size() > 0) ? vcyc0[0] - last_t : -1, 3);
        check("a5_byte", cap_byte(0, 0), 8'hA5);
        check("a5_bit0", (cap0.size() > 0) ? cap0[0] : 1'b0, 1);
        check("a5_bit1", (cap0.size() > 1) ? cap0[1] : 1'b1, 0);

        // Burst write across the top of memory, read back from address 0.
        wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33; wbuf[3] = 8'h44;
        frame(0, 1'b1, 'hFFE, 3, 0);
        clear_cap();
        frame(0, 1'b0, 'h000, 1, 0);
        check("wrap_b0", cap_byte(0, 0), 8'h33);
        check("wrap_b1", cap_byte(0, 1), 8'h44);

        // Three idle cycles before every bit of the write frame.
        wbuf[0] = 8'h5C;
        frame(0, 1'b1, 'h020, 0, 3);
        clear_cap();
        frame(0, 1'b0, 'h020, 0, 0);
        check("gap_byte", cap_byte(0, 0), 8'h5C);

        // Reset after two of four beats have been committed.
        wbuf[0] = 8'h01; wbuf[1] = 8'h02; wbuf[2] = 8'h03; wbuf[3] = 8'h04;
        frame(0, 1'b1, 'h030, 3, 0);
        drive(0, 1'b0, 1'b0, 1'b0);
        send_bits(0, 'h030, AW, 0, 1'b1);
        send_bits(0, 3, LW, 0, 1'b1);
        send_bits(0, 'hAA, DW, 0, 1'b1);
        send_bits(0, 'hBB, DW, 0, 1'b1);
        send_bits(0, 'hCC, 3, 0, 1'b1);
        drive(0, 1'b0, 1'b0, 1'b0);
        drive(0, 1'b0, 1'b0, 1'b0);
        rst[0] = 1'b1;
        drive(0, 1'b0, 1'b0, 1'b0);
        rst[0] = 1'b0;
        check("abort_sready", sready[0], 1);
        mwr(0, 'h030, 'hAA);
        mwr(0, 'h031, 'hBB);
        clear_cap();
        frame(0, 1'b0, 'h030, 3, 0);
        check("abort_b0", cap_byte(0, 0), 8'hAA);
        check("abort_b1", cap_byte(0, 1), 8'hBB);
        check("abort_b2", cap_byte(0, 2), 8'h03);
        check("abort_b3", cap_byte(0, 3), 8'h04);

        // Randomised traffic inside a 16-word window that straddles the wrap.
        for (int k = 0; k < 16; k++) wbuf[k] = 8'($urandom);
        frame(0, 1'b1, 'hFF8, 15, -1);
        for (int n = 0; n < 40; n++) begin
            r   = int'($urandom_range(0, 15));
            len = int'($urandom_range(0, 15 - r));
            a   = ('hFF8 + r) % (1 << AW);
            for (int k = 0; k < 16; k++) wbuf[k] = 8'($urandom);
            frame(0, rb(), a, len, -1);
        end

        // Split timing and out-of-range accesses on the small instance.
        wbuf[0] = 8'h77;
        frame(1, 1'b1, 'h100, 0, 0);
        wbuf[0] = 8'h55;
        frame(1, 1'b1, 'h900, 0, 0);
        clear_cap();
        frame(1, 1'b0, 'h900, 0, 0);
        check("oor_len", cap1.size(), 8);
        check("oor_byte", cap_byte(1, 0), 8'h00);
        check("split_cnt", split1.size(), 4);
        check("split_start", (split1.size() > 0) ? split1[0] - last_t : -1, 1);
        check("split_end", (split1.size() > 3 && vcyc1.size() > 0) ? vcyc1[0] - split1[3] : -1, 1);
        clear_cap();
        frame(1, 1'b0, 'h100, 0, 0);
        check("alias_byte", cap_byte(1, 0), 8'h77);

        repeat (4) drive(0, 1'b0, 1'b0, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
